interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 SHALL have parameter IF_ADDR, default 16'hFF0F, the bus address of the interrupt flag register.
REQ-002 SHALL have parameter IE_ADDR, default 16'hFFFF, the bus address of the interrupt enable register.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port address, input, 16, the CPU bus address (valid in the same cycle as RE/WE).
REQ-006 SHALL have port RE, input, 1, CPU read strobe.
REQ-007 SHALL have port WE, input, 1, CPU write strobe.
REQ-008 SHALL have port databus, inout tri, 8, the shared CPU data bus.
REQ-009 SHALL have ports vblank_req, lcdc_req, timer_req, serial_req, joypad_req, input, 1 each, level request lines from peripherals (bits 0..4).
REQ-010 SHALL have port int_clear, input, 1, one-cycle CPU acknowledge of the interrupt being serviced.
REQ-011 SHALL have ports vblank_int, lcdc_int, timer_int, serial_int, joypad_int, output, 1 each, registered IF bits 0..4.
REQ-012 SHALL have port int_en, output, 8, registered IE register contents.
REQ-013 SHALL have port int_pending, output, 1, OR of (IF[4:0] & IE[4:0]), combinational from registers.

Function
REQ-014 SHALL hold IF as a 5-bit register; IF reads return {3'b111, IF[4:0]}.
REQ-015 SHALL hold IE as a full 8-bit register; IE reads return IE[7:0].
REQ-016 SHALL register each request line into req_q every cycle, including during reset.
REQ-017 SHALL form set_mask[i] = req[i] & ~req_q[i] (rising edge), so IF[i] is visible high one cycle after req[i] is first sampled high.
REQ-018 SHALL form clr_mask as one-hot of the lowest-numbered i with IF[i] & IE[i] when int_clear=1; all zero if int_clear=0 or no such i.
REQ-019 SHALL compute IF_next = ((IF write ? databus[4:0] : IF) & ~clr_mask) | set_mask.
REQ-020 SHALL treat an IF write as WE=1 and address==IF_ADDR, capturing databus at the rising edge.
REQ-021 SHALL treat an IE write as WE=1 and address==IE_ADDR, IE_next = databus[7:0].
REQ-022 SHALL drive databus combinationally with the addressed register when RE=1, WE=0 and address matches IF_ADDR or IE_ADDR; otherwise 8'bz.
REQ-023 SHALL never drive databus when WE=1, regardless of RE.
REQ-024 SHALL ignore accesses to all other addresses, with no state change and databus at z.
REQ-025 SHALL let a same-cycle rising edge win over both int_clear and an IF write of 0 for that bit.
REQ-026 SHALL compute clr_mask from pre-write IF and IE, so a same-cycle IE write does not affect which bit is cleared.
REQ-027 SHALL hold a level request that stays high without setting IF again after it is cleared; a new rising edge is required.

Reset
REQ-028 SHALL on rst=1 at a rising edge set IF=5'b0 and IE=8'h00, and hold all *_int outputs, int_en and int_pending at 0.
REQ-029 SHALL give rst priority over writes, clears and edges in the same cycle, with req_q still loaded so lines held high through reset do not set IF.
REQ-030 SHALL leave databus at z during reset unless a qualifying read occurs (a read during reset returns 8'hE0 or 8'h00).

Verification
REQ-031 SHALL cover this case: with IE=8'h01, raise vblank_req at cycle n, so vblank_int=1 and int_pending=1 from cycle n+1; int_clear then gives vblank_int=0 the next cycle.
REQ-032 SHALL cover this case: with IF=5'b10100 and IE=8'h1F, pulse int_clear, so IF=5'b10000 (bit 2 cleared, bit 4 kept).
REQ-033 SHALL cover this case: write 8'hFF to IF_ADDR and then read it, so databus=8'hFF; write 8'h00 in the same cycle as a timer_req rising edge, so IF=5'b00100.
REQ-034 SHALL cover this case: with RE=1 and WE=1 at IE_ADDR, databus is not driven by the block and IE takes the CPU value; with RE=1 at 16'hFF10, databus is z.
REQ-035 SHALL cover this case: hold joypad_req=1 through rst and release, so IF stays 0; drop and re-raise it, so joypad_int=1 one cycle later.
REQ-036 SHALL cover this case: assert rst in the same cycle as an IE write of 8'h1F and a serial edge, so IE=8'h00 and IF=0 afterwards.

Source files
------------

// File: rtl/interrupt_controller.sv
// Interrupt flag (IF) / enable (IE) register pair with edge-detected peripheral requests,
// lowest-bit-first acknowledge clearing and a tristate CPU read port.
module interrupt_controller #(
    parameter logic [15:0] IF_ADDR = 16'hFF0F,
    parameter logic [15:0] IE_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] address,
    input  logic        RE,
    input  logic        WE,
    inout  tri   [7:0]  databus,
    input  logic        vblank_req,
    input  logic        lcdc_req,
    input  logic        timer_req,
    input  logic        serial_req,
    input  logic        joypad_req,
    input  logic        int_clear,
    output logic        vblank_int,
    output logic        lcdc_int,
    output logic        timer_int,
    output logic        serial_int,
    output logic        joypad_int,
    output logic [7:0]  int_en,
    output logic        int_pending
);

    localparam int unsigned N_IRQ  = 5;
    localparam int unsigned DATA_W = 8;

    logic [N_IRQ-1:0]  if_q;
    logic [DATA_W-1:0] ie_q;
    logic [N_IRQ-1:0]  req_q;

    logic [N_IRQ-1:0]  req;
    logic [N_IRQ-1:0]  set_mask;
    logic [N_IRQ-1:0]  pend;
    logic [N_IRQ-1:0]  pend_lsb;
    logic [N_IRQ-1:0]  clr_mask;
    logic [N_IRQ-1:0]  if_base;
    logic [N_IRQ-1:0]  if_next;
    logic              if_hit;
    logic              ie_hit;
    logic              if_wr;
    logic              ie_wr;
    logic              rd_drive;
    logic [DATA_W-1:0] rd_data;

    assign req      = {joypad_req, serial_req, timer_req, lcdc_req, vblank_req};
    assign set_mask = req & ~req_q;

    // Acknowledge clears only the highest-priority (lowest-numbered) pending source
    assign pend     = if_q & ie_q[N_IRQ-1:0];
    assign pend_lsb = pend & (~pend + N_IRQ'(1));
    assign clr_mask = int_clear ? pend_lsb : '0;

    assign if_hit = (address == IF_ADDR);
    assign ie_hit = (address == IE_ADDR);
    assign if_wr  = WE && if_hit;
    assign ie_wr  = WE && ie_hit;

    // New request edges override both the acknowledge and a CPU write of zero
    assign if_base = if_wr ? databus[N_IRQ-1:0] : if_q;
    assign if_next = (if_base & ~clr_mask) | set_mask;

    always_ff @(posedge clk) begin
        req_q <= req;
        if (rst) begin
            if_q <= '0;
            ie_q <= '0;
        end else begin
            if_q <= if_next;
            if (ie_wr) begin
                ie_q <= databus;
            end
        end
    end

    // Unused IF bits read back as ones
    assign rd_drive = RE && !WE && (if_hit || ie_hit);
    assign rd_data  = if_hit ? {3'b111, if_q} : ie_q;
    assign databus  = rd_drive ? rd_data : {DATA_W{1'bz}};

    assign vblank_int  = if_q[0];
    assign lcdc_int    = if_q[1];
    assign timer_int   = if_q[2];
    assign serial_int  = if_q[3];
    assign joypad_int  = if_q[4];
    assign int_en      = ie_q;
    assign int_pending = |pend;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: register access, edge detection,
// acknowledge priority, bus tristate behaviour and reset interactions.
module tb_interrupt_controller;

    localparam logic [15:0] IF_A  = 16'hFF0F;
    localparam logic [15:0] IE_A  = 16'hFFFF;
    localparam logic [15:0] BAD_A = 16'hFF10;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] address;
    logic        RE;
    logic        WE;
    tri0  [7:0]  databus;
    logic        vblank_req, lcdc_req, timer_req, serial_req, joypad_req;
    logic        int_clear;
    logic        vblank_int, lcdc_int, timer_int, serial_int, joypad_int;
    logic [7:0]  int_en;
    logic        int_pending;

    logic [7:0]  tb_data;
    logic        tb_oe;
    logic [7:0]  ints;

    int unsigned errors = 0;
    int unsigned checks = 0;

    assign databus = tb_oe ? tb_data : 8'bz;
    assign ints    = {3'b000, joypad_int, serial_int, timer_int, lcdc_int, vblank_int};

    interrupt_controller #(.IF_ADDR(IF_A), .IE_ADDR(IE_A)) dut (
        .clk         (clk),
        .rst         (rst),
        .address     (address),
        .RE          (RE),
        .WE          (WE),
        .databus     (databus),
        .vblank_req  (vblank_req),
        .lcdc_req    (lcdc_req),
        .timer_req   (timer_req),
        .serial_req  (serial_req),
        .joypad_req  (joypad_req),
        .int_clear   (int_clear),
        .vblank_int  (vblank_int),
        .lcdc_int    (lcdc_int),
        .timer_int   (timer_int),
        .serial_int  (serial_int),
        .joypad_int  (joypad_int),
        .int_en      (int_en),
        .int_pending (int_pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        address = a;
        WE      = 1'b1;
        tb_oe   = 1'b1;
        tb_data = d;
        step();
        WE      = 1'b0;
        tb_oe   = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [15:0] a, input logic [7:0] exp);
        address = a;
        RE      = 1'b1;
        #1;
        check(tag, databus, exp);
        RE      = 1'b0;
    endtask

    initial begin
        rst = 1'b1; address = 16'h0000; RE = 1'b0; WE = 1'b0;
        tb_oe = 1'b0; tb_data = 8'h00; int_clear = 1'b0;
        {vblank_req, lcdc_req, timer_req, serial_req, joypad_req} = 5'b0;
        step();
        step();
        rd("rd_if_in_reset", IF_A, 8'hE0);
        rst = 1'b0;
        step();
        check("rst_ints", ints, 8'h00);
        check("rst_ie", int_en, 8'h00);
        check("rst_pending", {7'b0, int_pending}, 8'h00);

        // vblank edge sets IF next cycle, acknowledge clears, held level does not re-set
        wr(IE_A, 8'h01);
        vblank_req = 1'b1;
        step();
        check("vblank_set", ints, 8'h01);
        check("vblank_pending", {7'b0, int_pending}, 8'h01);
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        check("vblank_cleared", ints, 8'h00);
        check("vblank_no_pending", {7'b0, int_pending}, 8'h00);
        step();
        check("vblank_level_held", ints, 8'h00);
        vblank_req = 1'b0;

        // Acknowledge picks lowest pending bit
        wr(IF_A, 8'h14);
        wr(IE_A, 8'h1F);
        rd("rd_if_14", IF_A, 8'hF4);
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        rd("clr_bit2_keep4", IF_A, 8'hF0);
        rd("rd_ie_1f", IE_A, 8'h1F);

        // Full write readback and edge beating a zero write
        wr(IF_A, 8'hFF);
        rd("rd_if_ff", IF_A, 8'hFF);
        timer_req = 1'b1;
        wr(IF_A, 8'h00);
        rd("edge_beats_wr0", IF_A, 8'hE4);
        check("timer_int", ints, 8'h04);
        timer_req = 1'b0;

        // Clear selection uses pre-write IE
        wr(IF_A, 8'h06);
        wr(IE_A, 8'h02);
        int_clear = 1'b1;
        wr(IE_A, 8'h04);
        int_clear = 1'b0;
        rd("clr_uses_old_ie", IF_A, 8'hE4);
        check("ie_after_clr", int_en, 8'h04);

        // Edge beats acknowledge on the same bit
        wr(IF_A, 8'h08);
        wr(IE_A, 8'h08);
        serial_req = 1'b1;
        int_clear = 1'b1;
        step();
        int_clear = 1'b0;
        check("edge_beats_clr", ints, 8'h08);
        serial_req = 1'b0;

        // Simultaneous RE and WE: block stays off the bus, IE captures CPU value
        wr(IE_A, 8'h15);
        address = IE_A; RE = 1'b1; WE = 1'b1; tb_oe = 1'b1; tb_data = 8'h0A;
        #1;
        check("re_we_bus", databus, 8'h0A);
        step();
        RE = 1'b0; WE = 1'b0; tb_oe = 1'b0;
        check("re_we_ie", int_en, 8'h0A);
        rd("rd_bad_addr_z", BAD_A, 8'h00);
        wr(BAD_A, 8'h33);
        check("bad_wr_ie", int_en, 8'h0A);
        rd("bad_wr_if", IF_A, 8'hE8);

        // Request held through reset does not set IF; re-raise does
        joypad_req = 1'b1;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        check("joy_held_rst", ints, 8'h00);
        joypad_req = 1'b0;
        step();
        joypad_req = 1'b1;
        step();
        check("joy_reraise", ints, 8'h10);
        joypad_req = 1'b0;

        // Reset wins over IE write and serial edge in the same cycle
        rst = 1'b1;
        serial_req = 1'b1;
        wr(IE_A, 8'h1F);
        rst = 1'b0;
        check("rst_wins_ie", int_en, 8'h00);
        check("rst_wins_if", ints, 8'h00);
        step();
        check("rst_serial_held", ints, 8'h00);
        check("rst_no_pending", {7'b0, int_pending}, 8'h00);
        serial_req = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
